// File: rtl/lzs_pkg.sv
// Shared widths, FSM state type and bit-format constants for the LZS decoder.
package lzs_pkg;

  localparam int IN_WIDTH       = 13;
  localparam int NEED_STR_WIDTH = 4;
  localparam int OUT_WIDTH      = 8;
  localparam int HIST_AW        = 11;

  typedef enum logic [2:0] {
    ST_TOKEN,
    ST_LEN,
    ST_LENX,
    ST_COPY,
    ST_DONE
  } state_t;

  // A short-offset of zero marks the end of the stream
  localparam logic [6:0]  END_OFFSET   = 7'd0;
  localparam logic [3:0]  LEN_EXT      = 4'b1111;
  localparam logic [15:0] LEN_BASE_2   = 16'd2;
  localparam logic [15:0] LEN_BASE_4   = 16'd5;
  localparam logic [15:0] LEN_BASE_EXT = 16'd8;
  localparam logic [15:0] LEN_EXT_STEP = 16'd15;

  localparam logic [3:0]  W_LITERAL    = 4'd9;
  localparam logic [3:0]  W_SHORT      = 4'd9;
  localparam logic [3:0]  W_LONG       = 4'd13;
  localparam logic [3:0]  W_LEN2       = 4'd2;
  localparam logic [3:0]  W_LEN4       = 4'd4;

endpackage

// File: rtl/lzs_hist_ram.sv
// Circular history buffer: one write port, one registered read port, no reset on contents.
module lzs_hist_ram #(
  parameter int AW = lzs_pkg::HIST_AW,
  parameter int DW = lzs_pkg::OUT_WIDTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/lzs_decode_core.sv
// LZS (RFC 1974) stream decoder: MSB-first token/length parser plus history copy engine.
// Optional per-token simulation trace when LZS_DECODE_TRACE_EN is defined.
module lzs_decode_core #(
  parameter int IN_WIDTH       = lzs_pkg::IN_WIDTH,
  parameter int NEED_STR_WIDTH = lzs_pkg::NEED_STR_WIDTH,
  parameter int OUT_WIDTH      = lzs_pkg::OUT_WIDTH,
  parameter int HIST_AW        = lzs_pkg::HIST_AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fo_full,
  input  logic [IN_WIDTH-1:0]       stream_data,
  input  logic                      stream_valid,
  output logic [NEED_STR_WIDTH-1:0] stream_width,
  output logic                      stream_ack,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic                      out_valid,
  output logic                      out_done
);

  import lzs_pkg::*;

  state_t               state_reg, state_next;
  logic [15:0]          len_reg, len_next;
  logic [HIST_AW-1:0]   off_reg, off_next;
  logic [HIST_AW-1:0]   rptr_reg, rptr_next;
  logic [HIST_AW-1:0]   wptr_reg;
  logic                 rd_pending_reg;
  logic                 byp_reg;
  logic [OUT_WIDTH-1:0] byp_data_reg;
  logic [OUT_WIDTH-1:0] out_data_reg;
  logic                 out_valid_reg;
  logic                 out_done_reg;

  logic                 can_ack;
  logic                 we;
  logic [OUT_WIDTH-1:0] wdata;
  logic                 re;
  logic [HIST_AW-1:0]   raddr;
  logic [OUT_WIDTH-1:0] ram_q;
  logic                 end_hit;
  logic                 len_done;
  logic [15:0]          final_len;
  logic [3:0]           nib;

  assign nib = stream_data[12:9];

  // New tokens wait while a copy byte is still in flight so only one byte is written per cycle
  assign can_ack = stream_valid && !fo_full && !rst && !rd_pending_reg;

  always_comb begin
    state_next   = state_reg;
    len_next     = len_reg;
    off_next     = off_reg;
    rptr_next    = rptr_reg;
    stream_ack   = 1'b0;
    stream_width = '0;
    we           = 1'b0;
    wdata        = '0;
    re           = 1'b0;
    raddr        = rptr_reg;
    end_hit      = 1'b0;
    len_done     = 1'b0;
    final_len    = '0;

    case (state_reg)
      ST_TOKEN: begin
        if (can_ack) begin
          stream_ack = 1'b1;
          if (!stream_data[12]) begin
            stream_width = NEED_STR_WIDTH'(W_LITERAL);
            we           = 1'b1;
            wdata        = OUT_WIDTH'(stream_data[11:4]);
          end else if (stream_data[11]) begin
            stream_width = NEED_STR_WIDTH'(W_SHORT);
            if (stream_data[10:4] == END_OFFSET) begin
              end_hit    = 1'b1;
              state_next = ST_DONE;
            end else begin
              off_next   = HIST_AW'(stream_data[10:4]);
              state_next = ST_LEN;
            end
          end else begin
            stream_width = NEED_STR_WIDTH'(W_LONG);
            off_next     = HIST_AW'(stream_data[10:0]);
            state_next   = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        if (can_ack) begin
          stream_ack = 1'b1;
          if (stream_data[12:11] != 2'b11) begin
            stream_width = NEED_STR_WIDTH'(W_LEN2);
            len_done     = 1'b1;
            final_len    = 16'(stream_data[12:11]) + LEN_BASE_2;
          end else if (nib == LEN_EXT) begin
            stream_width = NEED_STR_WIDTH'(W_LEN4);
            len_next     = '0;
            state_next   = ST_LENX;
          end else begin
            stream_width = NEED_STR_WIDTH'(W_LEN4);
            len_done     = 1'b1;
            final_len    = 16'(stream_data[10:9]) + LEN_BASE_4;
          end
        end
      end
      ST_LENX: begin
        if (can_ack) begin
          stream_ack   = 1'b1;
          stream_width = NEED_STR_WIDTH'(W_LEN4);
          if (nib == LEN_EXT) begin
            len_next = len_reg + LEN_EXT_STEP;
          end else begin
            len_done  = 1'b1;
            final_len = len_reg + LEN_BASE_EXT + 16'(nib);
          end
        end
      end
      ST_COPY: begin
        if (!fo_full) begin
          if (len_reg == 16'd0) begin
            state_next = ST_TOKEN;
          end else begin
            re        = 1'b1;
            raddr     = rptr_reg;
            rptr_next = rptr_reg + HIST_AW'(1);
            len_next  = len_reg - 16'd1;
            if (len_reg == 16'd1) state_next = ST_TOKEN;
          end
        end
      end
      ST_DONE: begin
      end
      default: state_next = ST_TOKEN;
    endcase

    // First copy read is issued in the length decision cycle to keep copy latency at two cycles
    if (len_done) begin
      if (final_len == 16'd0) begin
        len_next   = '0;
        state_next = ST_TOKEN;
      end else begin
        re         = 1'b1;
        raddr      = wptr_reg - off_reg;
        rptr_next  = raddr + HIST_AW'(1);
        len_next   = final_len - 16'd1;
        state_next = (final_len == 16'd1) ? ST_TOKEN : ST_COPY;
      end
    end

    if (rd_pending_reg && !fo_full) begin
      we    = 1'b1;
      wdata = byp_reg ? byp_data_reg : ram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_TOKEN;
      len_reg        <= '0;
      off_reg        <= '0;
      rptr_reg       <= '0;
      wptr_reg       <= '0;
      rd_pending_reg <= 1'b0;
      byp_reg        <= 1'b0;
      byp_data_reg   <= '0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      off_reg   <= off_next;
      rptr_reg  <= rptr_next;
      if (we) wptr_reg <= wptr_reg + HIST_AW'(1);
      if (!fo_full) rd_pending_reg <= re;
      // A read that hits the address being written this cycle sees stale RAM data
      if (re) begin
        byp_reg      <= we && (raddr == wptr_reg);
        byp_data_reg <= wdata;
      end
      out_valid_reg <= we;
      if (we) out_data_reg <= wdata;
      out_done_reg <= end_hit;
    end
  end

  lzs_hist_ram #(
    .AW (HIST_AW),
    .DW (OUT_WIDTH)
  ) u_hist (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_reg),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (ram_q)
  );

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_done  = out_done_reg;

`ifdef LZS_DECODE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && stream_ack) begin
      if (state_reg == ST_TOKEN && !stream_data[12])
        $display("[lzs] literal byte=%02h wptr=%0d", stream_data[11:4], wptr_reg);
      else if (end_hit)
        $display("[lzs] end wptr=%0d", wptr_reg);
      else if (len_done)
        $display("[lzs] match off=%0d len=%0d wptr=%0d", off_reg, final_len, wptr_reg);
    end
  end
`endif

endmodule

// File: tb/tb_lzs_decode_core.sv
// Scoreboard bench for lzs_decode_core: bit-level stream source, reference LZ history model.
module tb_lzs_decode_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        fo_full;
  logic [12:0] stream_data;
  logic        stream_valid;
  logic [3:0]  stream_width;
  logic        stream_ack;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_done;

  always #5 clk = ~clk;

  lzs_decode_core dut (
    .clk          (clk),
    .rst          (rst),
    .fo_full      (fo_full),
    .stream_data  (stream_data),
    .stream_valid (stream_valid),
    .stream_width (stream_width),
    .stream_ack   (stream_ack),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_done     (out_done)
  );

  int tests = 0;
  int fails = 0;

  bit         bits[$];
  int         exp_width[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] hist[$];
  int         ack_cycles[$];
  int         out_cycles[$];
  int         stall_start = -1;
  int         stall_len = 0;
  int         stall_pct = 0;

  task automatic add_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bits.push_back(v[i]);
    exp_width.push_back(n);
  endtask

  task automatic lit(input logic [7:0] b);
    add_bits(16'(b), 9);
    exp_bytes.push_back(b);
    hist.push_back(b);
  endtask

  task automatic match(input int off, input int len, input bit force_long);
    int rem;
    logic [7:0] b;
    logic [10:0] o;
    o = 11'(off);
    if (off < 128 && !force_long) add_bits({7'd0, 2'b11, o[6:0]}, 9);
    else add_bits({3'd0, 2'b10, o}, 13);
    if (len <= 4) add_bits(16'(len - 2), 2);
    else if (len <= 7) add_bits(16'(12 + len - 5), 4);
    else begin
      add_bits(16'hF, 4);
      rem = len - 8;
      while (rem >= 15) begin
        add_bits(16'hF, 4);
        rem -= 15;
      end
      add_bits(16'(rem), 4);
    end
    for (int i = 0; i < len; i++) begin
      b = hist[hist.size() - off];
      exp_bytes.push_back(b);
      hist.push_back(b);
    end
  endtask

  task automatic end_mark();
    add_bits(16'h180, 9);
    repeat (13) bits.push_back(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fo_full = 1'b0;
    stream_valid = 1'b1;
    stream_data = 13'h1FFF;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_done !== 1'b0 || out_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b done=%b data=%02h, need 0 0 00", out_valid, out_done, out_data);
    end
    tests++;
    if (stream_ack !== 1'b0 || stream_width !== 4'd0) begin
      fails++;
      $display("FAIL reset_ack: got ack=%b width=%0d, need 0 0", stream_ack, stream_width);
    end
    rst = 1'b0;
    stream_valid = 1'b0;
    stream_data = '0;
    bits.delete(); exp_width.delete(); exp_bytes.delete(); hist.delete();
    ack_cycles.delete(); out_cycles.delete();
    stall_start = -1; stall_len = 0; stall_pct = 0;
  endtask

  task automatic run_stream(input int budget, input int abort_at);
    int cyc = 0;
    int post_done = 0;
    bit done_seen = 0;
    bit ff_prev = 0;
    int w;
    logic [7:0] eb;
    logic [12:0] sd;
    while (cyc < budget && post_done < 4 && cyc != abort_at) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        tests++;
        if (ff_prev) begin
          fails++;
          $display("FAIL stall_out: got out_valid=1 data=%02h after fo_full cycle, need 0", out_data);
        end
        if (exp_bytes.size() == 0) begin
          fails++;
          $display("FAIL extra_byte: got %02h, need no byte", out_data);
        end else begin
          eb = exp_bytes.pop_front();
          if (out_data !== eb) begin
            fails++;
            $display("FAIL byte: got %02h, need %02h (cycle %0d)", out_data, eb, cyc);
          end else
            $display("[TB] cycle %0d byte %02h", cyc, out_data);
          out_cycles.push_back(cyc);
        end
      end
      if (out_done) begin
        tests++;
        if (done_seen || out_valid) begin
          fails++;
          $display("FAIL done_pulse: got done=1 again or with out_valid=%b, need single clean pulse", out_valid);
        end
        done_seen = 1;
        $display("[TB] cycle %0d done", cyc);
      end
      if (done_seen) post_done++;
      fo_full = (cyc >= stall_start && cyc < stall_start + stall_len) ||
                (stall_pct > 0 && $urandom_range(99) < stall_pct);
      stream_valid = (bits.size() >= 13);
      for (int i = 0; i < 13; i++) sd[12 - i] = (i < bits.size()) ? bits[i] : 1'b0;
      stream_data = sd;
      #2;
      if (stream_ack) begin
        tests++;
        if (fo_full || done_seen || !stream_valid) begin
          fails++;
          $display("FAIL ack_illegal: got ack=1 with fo_full=%b done=%b valid=%b, need ack=0", fo_full, done_seen, stream_valid);
        end
        w = int'(stream_width);
        if (exp_width.size() == 0) begin
          fails++;
          $display("FAIL extra_ack: got width %0d, need no ack", w);
        end else if (w != exp_width[0]) begin
          fails++;
          $display("FAIL ack_width: got %0d, need %0d", w, exp_width[0]);
          void'(exp_width.pop_front());
        end else
          void'(exp_width.pop_front());
        for (int i = 0; i < w && bits.size() > 0; i++) void'(bits.pop_front());
        ack_cycles.push_back(cyc);
      end
      ff_prev = fo_full;
      cyc++;
    end
    fo_full = 1'b0;
    if (abort_at < 0) begin
      tests++;
      if (!done_seen) begin
        fails++;
        $display("FAIL timeout: got no out_done within %0d cycles, need done", budget);
      end
      tests++;
      if (exp_bytes.size() != 0 || exp_width.size() != 0) begin
        fails++;
        $display("FAIL missing: got %0d bytes / %0d acks outstanding, need 0 0", exp_bytes.size(), exp_width.size());
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b0 || stream_ack !== 1'b0) begin
        fails++;
        $display("FAIL idle: got valid=%b ack=%b, need 0 0", out_valid, stream_ack);
      end
    end
  endtask

  task automatic test_literal();
    do_reset();
    lit(8'h41);
    end_mark();
    run_stream(200, -1);
    tests++;
    if (out_cycles.size() < 1 || ack_cycles.size() < 1 || out_cycles[0] != ack_cycles[0] + 1) begin
      fails++;
      $display("FAIL literal_latency: got %0d outputs, need byte one cycle after ack", out_cycles.size());
    end
  endtask

  task automatic test_overlap2();
    do_reset();
    lit(8'h41);
    lit(8'h42);
    match(2, 2, 1'b0);
    end_mark();
    run_stream(200, -1);
  endtask

  task automatic test_run_length();
    do_reset();
    lit(8'h55);
    match(1, 8, 1'b0);
    end_mark();
    run_stream(300, -1);
    tests++;
    if (out_cycles.size() != 9 || ack_cycles.size() < 4) begin
      fails++;
      $display("FAIL rle_count: got %0d bytes, need 9", out_cycles.size());
    end else begin
      tests++;
      if (out_cycles[1] - ack_cycles[3] > 2) begin
        fails++;
        $display("FAIL copy_latency: got %0d cycles, need <= 2", out_cycles[1] - ack_cycles[3]);
      end
      tests++;
      if (out_cycles[8] - out_cycles[1] != 7) begin
        fails++;
        $display("FAIL copy_rate: got span %0d, need 7", out_cycles[8] - out_cycles[1]);
      end
    end
  endtask

  task automatic test_long_match();
    do_reset();
    lit(8'h10);
    lit(8'h20);
    lit(8'h30);
    match(3, 23, 1'b1);
    end_mark();
    run_stream(400, -1);
  endtask

  task automatic test_stall();
    do_reset();
    lit(8'h11);
    lit(8'h22);
    lit(8'h33);
    match(3, 12, 1'b0);
    end_mark();
    stall_start = 9;
    stall_len = 3;
    run_stream(400, -1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 6; i++) lit(8'($urandom_range(255)));
    match(4, 5, 1'b0);
    lit(8'hC3);
    match(1, 3, 1'b0);
    match(7, 22, 1'b0);
    match(10, 40, 1'b1);
    end_mark();
    stall_pct = 25;
    run_stream(2000, -1);
  endtask

  task automatic test_mid_reset();
    do_reset();
    lit(8'hA5);
    match(1, 200, 1'b0);
    run_stream(200, 20);
    do_reset();
    lit(8'h01);
    lit(8'h02);
    match(2, 3, 1'b0);
    end_mark();
    run_stream(300, -1);
  endtask

  task automatic test_end_marker();
    do_reset();
    end_mark();
    run_stream(100, -1);
    tests++;
    if (out_cycles.size() != 0) begin
      fails++;
      $display("FAIL end_bytes: got %0d bytes, need 0", out_cycles.size());
    end
    do_reset();
    lit(8'h7E);
    end_mark();
    run_stream(100, -1);
  endtask

  initial begin
    test_reset();
    test_literal();
    test_overlap2();
    test_run_length();
    test_long_match();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_end_marker();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
